// File: rtl/window_sum_judge.sv
// Per-channel hysteresis judge behind slide_window: keeps a detect bit per channel, emits rise/fall events and a live alarm count.
// Optional peak tracker (peak_sum/peak_addr/peak_clr) is compiled in with JUDGE_PEAK_EN.
module window_sum_judge #(
    parameter int CHANNELS = 600,
    parameter int AW       = 10,
    parameter int SW       = 8,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          win_done,
    input  logic [SW-1:0] win_sum,
    input  logic [AW-1:0] win_addr,
    input  logic [SW-1:0] th_hi,
    input  logic [SW-1:0] th_lo,
    input  logic          err_clr,
`ifdef JUDGE_PEAK_EN
    input  logic          peak_clr,
    output logic [SW-1:0] peak_sum,
    output logic [AW-1:0] peak_addr,
`endif
    output logic          ready,
    output logic          det_valid,
    output logic [AW-1:0] det_addr,
    output logic          det_state,
    output logic          det_rise,
    output logic          det_fall,
    output logic [CW-1:0] alarm_cnt,
    output logic [2:0]    err
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_EV} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_init_addr;
    logic [AW-1:0] r_addr;
    logic [SW-1:0] r_sum;
    logic          r_old;
    logic          r_mem [CHANNELS];

    logic          r_ev_vld, r_ev_state, r_ev_rise, r_ev_fall;
    logic [AW-1:0] r_ev_addr;

    logic          r_ready, r_det_valid, r_det_state, r_det_rise, r_det_fall;
    logic [AW-1:0] r_det_addr;
    logic [CW-1:0] r_alarm_cnt;
    logic [2:0]    r_err;

    logic          w_init_last, w_addr_ok, w_th_bad, w_rise, w_fall, w_new;
    logic          w_we, w_wdata;
    logic [AW-1:0] w_waddr;
    logic [2:0]    w_err_set;

    assign w_init_last = (r_init_addr == AW'(CHANNELS - 1));
    assign w_addr_ok   = (win_addr < AW'(CHANNELS));
    assign w_th_bad    = (th_lo >= th_hi);
    assign w_rise      = !w_th_bad && !r_old && (r_sum >= th_hi);
    assign w_fall      = !w_th_bad &&  r_old && (r_sum <= th_lo);
    assign w_new       = w_rise ? 1'b1 : (w_fall ? 1'b0 : r_old);

    assign w_err_set[0] = ((r_state == S_RD) || (r_state == S_EV)) && win_done;
    assign w_err_set[1] = (r_state == S_IDLE) && win_done && !w_addr_ok;
    assign w_err_set[2] = (r_state == S_EV) && w_th_bad;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (w_init_last) w_next = S_IDLE;
            S_IDLE:  if (win_done && w_addr_ok) w_next = S_RD;
            S_RD:    w_next = S_EV;
            S_EV:    w_next = S_IDLE;
            default: w_next = S_INIT;
        endcase
    end

    // Single write port shared by the init sweep and the EV write-back
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_init_addr;
        w_wdata = 1'b0;
        if (r_state == S_INIT) begin
            w_we = 1'b1;
        end else if (r_state == S_EV) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_init_addr <= '0;
            r_addr      <= '0;
            r_sum       <= '0;
            r_old       <= 1'b0;
            r_ev_vld    <= 1'b0;
            r_ev_state  <= 1'b0;
            r_ev_rise   <= 1'b0;
            r_ev_fall   <= 1'b0;
            r_ev_addr   <= '0;
            r_ready     <= 1'b0;
            r_det_valid <= 1'b0;
            r_det_addr  <= '0;
            r_det_state <= 1'b0;
            r_det_rise  <= 1'b0;
            r_det_fall  <= 1'b0;
            r_alarm_cnt <= '0;
            r_err       <= '0;
        end else begin
            if (r_state == S_INIT) begin
                r_init_addr <= r_init_addr + AW'(1);
                if (w_init_last) r_ready <= 1'b1;
            end
            if (r_state == S_IDLE && win_done) begin
                r_addr <= win_addr;
                r_sum  <= win_sum;
            end
            if (r_state == S_RD) r_old <= r_mem[r_addr];

            // EV result is staged once more so det_* land on the third edge
            r_ev_vld <= (r_state == S_EV);
            if (r_state == S_EV) begin
                r_ev_addr  <= r_addr;
                r_ev_state <= w_new;
                r_ev_rise  <= w_rise;
                r_ev_fall  <= w_fall;
            end

            r_det_valid <= r_ev_vld;
            if (r_ev_vld) begin
                r_det_addr  <= r_ev_addr;
                r_det_state <= r_ev_state;
                r_det_rise  <= r_ev_rise;
                r_det_fall  <= r_ev_fall;
                if (r_ev_rise)      r_alarm_cnt <= r_alarm_cnt + CW'(1);
                else if (r_ev_fall) r_alarm_cnt <= r_alarm_cnt - CW'(1);
            end

            r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
        end
    end

`ifdef JUDGE_PEAK_EN
    logic [SW-1:0] r_peak_sum;
    logic [AW-1:0] r_peak_addr;

    // Strict compare keeps the earliest channel on ties; an update beats peak_clr
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_peak_sum  <= '0;
            r_peak_addr <= '0;
        end else if (r_state == S_EV && r_sum > r_peak_sum) begin
            r_peak_sum  <= r_sum;
            r_peak_addr <= r_addr;
        end else if (peak_clr) begin
            r_peak_sum  <= '0;
            r_peak_addr <= '0;
        end
    end

    assign peak_sum  = r_peak_sum;
    assign peak_addr = r_peak_addr;
`endif

    assign ready     = r_ready;
    assign det_valid = r_det_valid;
    assign det_addr  = r_det_addr;
    assign det_state = r_det_state;
    assign det_rise  = r_det_rise;
    assign det_fall  = r_det_fall;
    assign alarm_cnt = r_alarm_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_window_sum_judge.sv
// Scoreboard bench for window_sum_judge: a reference model pushes expected det results, a monitor pops them on det_valid.
// Peak-tracker checks are compiled in with JUDGE_PEAK_EN.
module tb_window_sum_judge;
    localparam int CH = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       win_done = 1'b0;
    logic [7:0] win_sum = '0;
    logic [9:0] win_addr = '0;
    logic [7:0] th_hi = 8'd30;
    logic [7:0] th_lo = 8'd20;
    logic       err_clr = 1'b0;
    logic       peak_clr = 1'b0;
    logic [7:0] peak_sum;
    logic [9:0] peak_addr;
    logic       ready, det_valid, det_state, det_rise, det_fall;
    logic [9:0] det_addr;
    logic [9:0] alarm_cnt;
    logic [2:0] err;

    window_sum_judge dut (
        .clk(clk), .reset(reset), .win_done(win_done), .win_sum(win_sum),
        .win_addr(win_addr), .th_hi(th_hi), .th_lo(th_lo), .err_clr(err_clr),
`ifdef JUDGE_PEAK_EN
        .peak_clr(peak_clr), .peak_sum(peak_sum), .peak_addr(peak_addr),
`endif
        .ready(ready), .det_valid(det_valid), .det_addr(det_addr),
        .det_state(det_state), .det_rise(det_rise), .det_fall(det_fall),
        .alarm_cnt(alarm_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit st;
        bit rise;
        bit fall;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q[$];
    bit   model [CH];
    int   mcnt = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    // Monitor: every det_valid must match the oldest expected result, including its cycle
    always @(posedge clk) begin
        #1;
        if (det_valid === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL det_unexpected: got det_valid addr=%0d at cyc %0d, required none", det_addr, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({det_addr, det_state, det_rise, det_fall, alarm_cnt} !==
                    {10'(e.addr), e.st, e.rise, e.fall, 10'(e.cnt)} || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL det_result: got addr=%0d st=%0b r=%0b f=%0b cnt=%0d cyc=%0d, required addr=%0d st=%0b r=%0b f=%0b cnt=%0d cyc=%0d",
                             det_addr, det_state, det_rise, det_fall, alarm_cnt, cyc,
                             e.addr, e.st, e.rise, e.fall, e.cnt, e.cyc);
                end
            end
        end
    end

    // Reference model for one accepted sum, sampled on the next posedge
    task automatic expect_eval(input int addr, input int sum);
        exp_t e;
        bit bad, old;
        bad = (th_lo >= th_hi);
        old = model[addr];
        e.addr = addr;
        e.rise = !bad && !old && (sum >= int'(th_hi));
        e.fall = !bad && old && (sum <= int'(th_lo));
        e.st   = e.rise ? 1'b1 : (e.fall ? 1'b0 : old);
        if (e.rise) mcnt++;
        if (e.fall) mcnt--;
        model[addr] = e.st;
        e.cnt = mcnt;
        e.cyc = cyc + 4;
        q.push_back(e);
    endtask

    task automatic send(input int addr, input int sum);
        @(negedge clk);
        win_done = 1'b1;
        win_addr = 10'(addr);
        win_sum  = 8'(sum);
        if (addr < CH) expect_eval(addr, sum);
        @(negedge clk);
        win_done = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_err(input string name, input logic [2:0] req);
        n_chk++;
        if (err !== req) begin
            n_fail++;
            $display("FAIL %s: got err=%03b, required %03b", name, err, req);
        end
    endtask

    task automatic check_cnt(input string name, input int req);
        n_chk++;
        if (alarm_cnt !== 10'(req)) begin
            n_fail++;
            $display("FAIL %s: got alarm_cnt=%0d, required %0d", name, alarm_cnt, req);
        end
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 100) win_done = 1'b1;
            if (n == 101) win_done = 1'b0;
        end
        n_chk++;
        if (n != CH) begin
            n_fail++;
            $display("FAIL %s: got ready after %0d cycles, required %0d", name, n, CH);
        end
    endtask

    task automatic reset_model();
        foreach (model[i]) model[i] = 1'b0;
        mcnt = 0;
        q.delete();
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ready, det_valid, det_addr, det_state, det_rise, det_fall, alarm_cnt, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b dv=%0b cnt=%0d err=%03b, required all 0",
                     ready, det_valid, alarm_cnt, err);
        end
        reset_model();
        reset = 1'b1;
        wait_ready("reset_ready_delay", n);
        check_err("init_win_done_ignored", 3'b000);
        check_cnt("init_alarm_cnt", 0);
    endtask

    task automatic test_hysteresis();
        th_hi = 8'd30;
        th_lo = 8'd20;
        send(5, 29);
        send(5, 30);
        check_cnt("hyst_after_rise", 1);
        send(5, 25);
        send(5, 20);
        check_cnt("hyst_after_fall", 0);
    endtask

    task automatic test_multi_addr();
        send(0, 40);
        send(599, 40);
        send(300, 40);
        check_cnt("multi_cnt3", 3);
        send(600, 40);
        check_err("addr_range_err", 3'b010);
        check_cnt("addr_range_cnt", 3);
        pulse_err_clr();
        check_err("err_clr_range", 3'b000);
    endtask

    task automatic test_threshold();
        th_hi = 8'd20;
        th_lo = 8'd30;
        send(7, 40);
        check_err("th_bad_err", 3'b100);
        check_cnt("th_bad_cnt", 3);
        th_hi = 8'd30;
        th_lo = 8'd20;
        pulse_err_clr();
        check_err("err_clr_th", 3'b000);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        win_done = 1'b1; win_addr = 10'd8; win_sum = 8'd40;
        expect_eval(8, 40);
        @(negedge clk);
        win_done = 1'b0;
        @(negedge clk);
        win_done = 1'b1; win_addr = 10'd9; win_sum = 8'd40;
        @(negedge clk);
        win_done = 1'b0;
        repeat (6) @(negedge clk);
        check_err("overrun_err", 3'b001);
        check_cnt("overrun_cnt", 4);
        // clear and a new range error on the same edge: new error survives
        @(negedge clk);
        err_clr = 1'b1; win_done = 1'b1; win_addr = 10'd700;
        @(negedge clk);
        err_clr = 1'b0; win_done = 1'b0;
        check_err("clr_vs_new_err", 3'b010);
        pulse_err_clr();
        check_err("err_clr_final", 3'b000);
    endtask

    task automatic test_reset_abort();
        int n;
        @(negedge clk);
        win_done = 1'b1; win_addr = 10'd0; win_sum = 8'd0;
        @(negedge clk);
        win_done = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++;
        if ({ready, det_valid, alarm_cnt, err} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: got rdy=%0b dv=%0b cnt=%0d err=%03b, required all 0",
                     ready, det_valid, alarm_cnt, err);
        end
        reset_model();
        reset = 1'b1;
        wait_ready("abort_ready_delay", n);
        send(0, 25);
        check_cnt("abort_cnt_after", 0);
    endtask

`ifdef JUDGE_PEAK_EN
    task automatic test_peak();
        send(1, 10);
        send(2, 50);
        send(3, 50);
        send(4, 7);
        n_chk++;
        if (peak_sum !== 8'd50 || peak_addr !== 10'd2) begin
            n_fail++;
            $display("FAIL peak_value: got sum=%0d addr=%0d, required 50 2", peak_sum, peak_addr);
        end
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        n_chk++;
        if (peak_sum !== 8'd0 || peak_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL peak_clr: got sum=%0d addr=%0d, required 0 0", peak_sum, peak_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hysteresis();
        test_multi_addr();
        test_threshold();
        test_back_to_back();
        test_reset_abort();
`ifdef JUDGE_PEAK_EN
        test_peak();
`endif
        repeat (10) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL det_missing: got %0d results outstanding, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
